// File: rtl/networkadapter_wb_decode.sv
// networkadapter_wb_decode: Wishbone front-end that decodes tile-bus accesses to conf/mp_simple/DMA targets
module networkadapter_wb_decode #(
  parameter int unsigned TIMEOUT   = 255,
  parameter int unsigned CNT_WIDTH = 16
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic [31:0]          wb_adr_i,
  input  logic                 wb_cyc_i,
  input  logic                 wb_stb_i,
  input  logic                 wb_we_i,
  input  logic [31:0]          wb_dat_i,
  output logic [31:0]          wb_dat_o,
  output logic                 wb_ack_o,
  output logic                 wb_err_o,
  output logic                 wb_rty_o,
  output logic [15:0]          tgt_adr,
  output logic                 tgt_we,
  output logic [31:0]          tgt_dat_o,
  output logic [2:0]           tgt_stb,
  input  logic [2:0]           tgt_ack,
  input  logic [2:0]           tgt_err,
  input  logic [2:0]           tgt_rty,
  input  logic [95:0]          tgt_dat_i,
  output logic [CNT_WIDTH-1:0] err_count
);
  localparam logic [1:0] IDLE = 2'd0, ACCESS = 2'd1, RESP = 2'd2;
  logic [1:0]  state;
  logic [1:0]  region;
  logic [31:0] tmo_cnt;
  logic        hit_ack, hit_err, hit_rty, tmo, done, resp_err, req, unmapped, cnt_up;
  logic        unused_adr;
  assign unused_adr = ^wb_adr_i[31:16];
  // Only the strobed target's response bits count; ack beats err beats rty, timeout yields err
  always_comb begin
    hit_ack  = |(tgt_ack & tgt_stb);
    hit_err  = |(tgt_err & tgt_stb);
    hit_rty  = |(tgt_rty & tgt_stb);
    tmo      = (TIMEOUT != 0) && (tmo_cnt == TIMEOUT - 1);
    done     = hit_ack || hit_err || hit_rty || tmo;
    resp_err = !hit_ack && (hit_err || !hit_rty);
    req      = wb_cyc_i && wb_stb_i;
    unmapped = wb_adr_i[15:14] == 2'd3;
    cnt_up   = (state == IDLE && req && unmapped) || (state == ACCESS && wb_cyc_i && done && resp_err);
  end
  // Access sequencer: latch request, hold target strobe, register a one-cycle Wishbone response
  always_ff @(posedge clk or posedge rst)
    if (rst) begin
      state     <= IDLE;
      region    <= 2'd0;
      tmo_cnt   <= 32'd0;
      tgt_stb   <= 3'b000;
      tgt_adr   <= 16'd0;
      tgt_we    <= 1'b0;
      tgt_dat_o <= 32'd0;
      wb_dat_o  <= 32'd0;
      wb_ack_o  <= 1'b0;
      wb_err_o  <= 1'b0;
      wb_rty_o  <= 1'b0;
    end else begin
      wb_ack_o <= 1'b0;
      wb_err_o <= 1'b0;
      wb_rty_o <= 1'b0;
      case (state)
        IDLE: if (req) begin
          tgt_adr   <= {2'b00, wb_adr_i[13:0]};
          tgt_we    <= wb_we_i;
          tgt_dat_o <= wb_dat_i;
          region    <= wb_adr_i[15:14];
          tmo_cnt   <= 32'd0;
          if (unmapped) begin
            state    <= RESP;
            wb_err_o <= 1'b1;
            wb_dat_o <= 32'd0;
          end else begin
            state   <= ACCESS;
            tgt_stb <= 3'b001 << wb_adr_i[15:14];
          end
        end
        ACCESS: if (!wb_cyc_i) begin
          state   <= IDLE;
          tgt_stb <= 3'b000;
        end else if (done) begin
          state    <= RESP;
          tgt_stb  <= 3'b000;
          wb_ack_o <= hit_ack;
          wb_err_o <= resp_err;
          wb_rty_o <= !hit_ack && !hit_err && hit_rty;
          wb_dat_o <= hit_ack ? tgt_dat_i[{region, 5'd0} +: 32] : 32'd0;
        end else if (TIMEOUT != 0) tmo_cnt <= tmo_cnt + 32'd1;
        default: state <= IDLE;
      endcase
    end
  // Saturating count of error terminations
  always_ff @(posedge clk or posedge rst)
    if (rst) err_count <= '0;
    else if (cnt_up && !(&err_count)) err_count <= err_count + CNT_WIDTH'(1);
endmodule

// File: tb/tb_networkadapter_wb_decode.sv
// tb_networkadapter_wb_decode: directed bench with a transaction-level model of the decoder
module tb_networkadapter_wb_decode;
  localparam int TO   = 4;
  localparam int CW   = 2;
  localparam int CMAX = (1 << CW) - 1;
  logic          clk = 1'b0;
  logic          rst = 1'b1;
  logic [31:0]   wb_adr_i = '0, wb_dat_i = '0;
  logic          wb_cyc_i = 1'b0, wb_stb_i = 1'b0, wb_we_i = 1'b0;
  logic [31:0]   wb_dat_o;
  logic          wb_ack_o, wb_err_o, wb_rty_o;
  logic [15:0]   tgt_adr;
  logic          tgt_we;
  logic [31:0]   tgt_dat_o;
  logic [2:0]    tgt_stb, tgt_ack, tgt_err, tgt_rty;
  logic [95:0]   tgt_dat_i;
  logic [CW-1:0] err_count;
  int            delay [3];
  logic [2:0]    kind [3];
  logic [31:0]   tdat [3];
  logic [2:0]    noise = 3'b000;
  int            scnt = 0;
  int            vecs = 0, errs = 0, model_cnt = 0;
  logic [2:0]    exp_stb = '0;
  logic          exp_ack = 0, exp_err = 0, exp_rty = 0, exp_we = 0;
  logic [31:0]   exp_dat = '0, exp_tdat = '0;
  logic [15:0]   exp_adr = '0;

  networkadapter_wb_decode #(.TIMEOUT(TO), .CNT_WIDTH(CW)) dut (
    .clk(clk), .rst(rst), .wb_adr_i(wb_adr_i), .wb_cyc_i(wb_cyc_i), .wb_stb_i(wb_stb_i),
    .wb_we_i(wb_we_i), .wb_dat_i(wb_dat_i), .wb_dat_o(wb_dat_o), .wb_ack_o(wb_ack_o),
    .wb_err_o(wb_err_o), .wb_rty_o(wb_rty_o), .tgt_adr(tgt_adr), .tgt_we(tgt_we),
    .tgt_dat_o(tgt_dat_o), .tgt_stb(tgt_stb), .tgt_ack(tgt_ack), .tgt_err(tgt_err),
    .tgt_rty(tgt_rty), .tgt_dat_i(tgt_dat_i), .err_count(err_count)
  );

  always #5 clk = ~clk;

  assign tgt_dat_i = {tdat[2], tdat[1], tdat[0]};

  // Targets: respond with 'kind' once strobed for 'delay' cycles; 'noise' acks regardless of strobe
  always @(posedge clk) scnt <= (tgt_stb != 3'b000) ? scnt + 1 : 0;
  always_comb begin
    tgt_ack = noise;
    tgt_err = 3'b000;
    tgt_rty = 3'b000;
    for (int n = 0; n < 3; n++)
      if (tgt_stb[n] && scnt == delay[n]) begin
        tgt_ack[n] = tgt_ack[n] | kind[n][0];
        tgt_err[n] = kind[n][1];
        tgt_rty[n] = kind[n][2];
      end
  end

  task automatic check(input string nm, input logic [31:0] act, input logic [31:0] exp);
    vecs++;
    if (act !== exp) begin
      errs++;
      $display("FAIL %s at %0t: got %h expected %h", nm, $time, act, exp);
    end
  endtask

  // Every cycle, all outputs against the model's expectations
  always @(negedge clk) begin
    check("tgt_stb", 32'(tgt_stb), 32'(exp_stb));
    check("wb_ack_o", 32'(wb_ack_o), 32'(exp_ack));
    check("wb_err_o", 32'(wb_err_o), 32'(exp_err));
    check("wb_rty_o", 32'(wb_rty_o), 32'(exp_rty));
    check("wb_dat_o", wb_dat_o, exp_dat);
    check("err_count", 32'(err_count), 32'(model_cnt));
    check("tgt_adr", 32'(tgt_adr), 32'(exp_adr));
    check("tgt_we", 32'(tgt_we), 32'(exp_we));
    check("tgt_dat_o", tgt_dat_o, exp_tdat);
  end

  // One complete access: the model derives strobe length and termination from region and target setup
  task automatic xfer(input logic [31:0] adr, input logic we, input logic [31:0] dat);
    int r, n;
    logic [2:0] typ;
    r = int'(adr[15:14]);
    if (r == 3) begin n = 0; typ = 3'b010; end
    else if (delay[r] >= 0 && delay[r] < TO) begin
      n = delay[r] + 1;
      typ = kind[r][0] ? 3'b001 : kind[r][1] ? 3'b010 : 3'b100;
    end else begin n = TO; typ = 3'b010; end
    wb_adr_i = adr; wb_we_i = we; wb_dat_i = dat; wb_cyc_i = 1'b1; wb_stb_i = 1'b1;
    @(posedge clk); #1;
    exp_adr = {2'b00, adr[13:0]}; exp_we = we; exp_tdat = dat;
    for (int i = 0; i < n; i++) begin
      exp_stb = 3'b001 << r;
      @(posedge clk); #1;
    end
    exp_stb = 3'b000;
    {exp_rty, exp_err, exp_ack} = typ;
    exp_dat = typ[0] ? tdat[r] : 32'd0;
    if (typ[1] && model_cnt < CMAX) model_cnt++;
    wb_cyc_i = 1'b0; wb_stb_i = 1'b0;
    @(posedge clk); #1;
    {exp_rty, exp_err, exp_ack} = 3'b000;
  endtask

  initial begin
    for (int n = 0; n < 3; n++) begin delay[n] = -1; kind[n] = 3'b000; tdat[n] = 32'd0; end
    repeat (2) @(posedge clk);
    #1;
    check("reset wb_dat_o", wb_dat_o, 32'd0);
    check("reset err_count", 32'(err_count), 32'd0);
    check("reset tgt_stb", 32'(tgt_stb), 32'd0);
    rst = 1'b0;
    @(posedge clk); #1;
    // conf read, combinational ack
    delay[0] = 0; kind[0] = 3'b001; tdat[0] = 32'h0000_0010;
    xfer(32'h0000_0004, 1'b0, 32'd0);
    check("conf read data", wb_dat_o, 32'h0000_0010);
    // DMA write, ack after 3 cycles
    delay[2] = 3; kind[2] = 3'b001; tdat[2] = 32'hCAFE_0002;
    xfer(32'h0000_8010, 1'b1, 32'hDEAD_BEEF);
    check("dma tgt_dat_o", tgt_dat_o, 32'hDEAD_BEEF);
    check("dma tgt_adr", 32'(tgt_adr), 32'h0010);
    check("dma tgt_we", 32'(tgt_we), 32'd1);
    // unmapped region
    xfer(32'h0000_C000, 1'b0, 32'd0);
    check("unmapped count", 32'(err_count), 32'd1);
    // silent mp_simple target times out, then ack lands in the timeout cycle
    delay[1] = -1; kind[1] = 3'b001; tdat[1] = 32'h2222_2222;
    xfer(32'h0000_4000, 1'b0, 32'd0);
    check("timeout count", 32'(err_count), 32'd2);
    delay[1] = TO - 1;
    xfer(32'h0000_4004, 1'b0, 32'd0);
    check("late ack count", 32'(err_count), 32'd2);
    check("late ack data", wb_dat_o, 32'h2222_2222);
    // ack+err together from target 0 while unselected target 1 acks
    delay[0] = 1; kind[0] = 3'b011; tdat[0] = 32'h1111_1111; noise = 3'b010;
    xfer(32'h0000_0008, 1'b1, 32'h5555_AAAA);
    check("priority data", wb_dat_o, 32'h1111_1111);
    noise = 3'b000;
    // retry from target 0
    delay[0] = 0; kind[0] = 3'b100;
    xfer(32'h0000_000C, 1'b0, 32'd0);
    check("rty count", 32'(err_count), 32'd2);
    check("rty data", wb_dat_o, 32'd0);
    // target error from DMA
    delay[2] = 1; kind[2] = 3'b010;
    xfer(32'h0000_8000, 1'b0, 32'd0);
    check("tgt err count", 32'(err_count), 32'd3);
    // abort: cyc dropped in the second access cycle
    delay[1] = -1;
    wb_adr_i = 32'h0000_4020; wb_we_i = 1'b0; wb_dat_i = 32'h1234_5678; wb_cyc_i = 1'b1; wb_stb_i = 1'b1;
    @(posedge clk); #1;
    exp_adr = 16'h0020; exp_we = 1'b0; exp_tdat = 32'h1234_5678; exp_stb = 3'b010;
    @(posedge clk); #1;
    wb_cyc_i = 1'b0; wb_stb_i = 1'b0;
    @(posedge clk); #1;
    exp_stb = 3'b000;
    check("abort tgt_stb", 32'(tgt_stb), 32'd0);
    repeat (2) begin @(posedge clk); #1; end
    // asynchronous reset in the middle of an access
    wb_adr_i = 32'h0000_4008; wb_cyc_i = 1'b1; wb_stb_i = 1'b1;
    @(posedge clk); #1;
    exp_adr = 16'h0008; exp_tdat = 32'h1234_5678; exp_stb = 3'b010;
    @(posedge clk); #1;
    #2;
    rst = 1'b1;
    exp_stb = '0; exp_adr = '0; exp_tdat = '0; exp_we = 1'b0; exp_dat = '0; model_cnt = 0;
    #1;
    check("async rst tgt_stb", 32'(tgt_stb), 32'd0);
    check("async rst tgt_adr", 32'(tgt_adr), 32'd0);
    check("async rst err_count", 32'(err_count), 32'd0);
    check("async rst wb_dat_o", wb_dat_o, 32'd0);
    wb_cyc_i = 1'b0; wb_stb_i = 1'b0;
    @(posedge clk); #1;
    rst = 1'b0;
    @(posedge clk); #1;
    // saturation: five errors on a 2-bit counter
    repeat (5) xfer(32'h0000_C010, 1'b0, 32'd0);
    check("saturated count", 32'(err_count), 32'd3);
    repeat (2) @(posedge clk);
    $display("== %0d vectors applied, %0d miscompares ==", vecs, errs);
    $finish;
  end
endmodule

// File: doc/networkadapter_wb_decode.md
# networkadapter_wb_decode

Bus front-end of the compute-tile network adapter. Accepts Wishbone classic single-cycle accesses from the tile bus, decodes the region (configuration registers, mp_simple, DMA), and forwards each access to exactly one target with a held strobe. Registers the target's ack/err/rty and read data into a one-cycle Wishbone response. Also terminates dead or unmapped accesses with a bus error, and counts error terminations.

## Interface
Parameters:
- TIMEOUT, 255, cycles an access may wait for a target response before error termination; 0 disables timeout
- CNT_WIDTH, 16, width of the saturating error counter

Ports:
- clk  in  1  clock
- rst  in  1  asynchronous, active-high reset
- wb_adr_i  in  32  byte address; [15:14] region, [13:0] offset
- wb_cyc_i  in  1  bus cycle valid
- wb_stb_i  in  1  strobe
- wb_we_i  in  1  write enable
- wb_dat_i  in  32  write data
- wb_dat_o  out  32  read data, registered
- wb_ack_o  out  1  normal termination, one-cycle pulse
- wb_err_o  out  1  error termination, one-cycle pulse
- wb_rty_o  out  1  retry termination, one-cycle pulse
- tgt_adr  out  16  {2'b00, latched wb_adr_i[13:0]}
- tgt_we  out  1  latched wb_we_i
- tgt_dat_o  out  32  latched wb_dat_i
- tgt_stb  out  3  one-hot strobe: bit0 conf, bit1 mp_simple, bit2 DMA
- tgt_ack  in  3  per-target ack
- tgt_err  in  3  per-target err
- tgt_rty  in  3  per-target rty
- tgt_dat_i  in  96  per-target read data; target n at [32n+31:32n]
- err_count  out  CNT_WIDTH  saturating count of error terminations (timeout, unmapped, target err)

## Operation
- States: IDLE, ACCESS, RESP.
- IDLE: on wb_cyc_i & wb_stb_i at a clock edge, latch adr/we/dat and region.
  - Region 0..2: go to ACCESS, set tgt_stb one-hot, clear timeout counter.
  - Region 3 (unmapped): go to RESP with err, no target strobe.
- ACCESS: tgt_stb held; only the selected target's ack/err/rty bits are observed.
  - Selected target asserts a response: go to RESP, latch type and tgt_dat_i of that target into wb_dat_o (data latched on ack only, otherwise 0).
  - Priority when several are asserted: ack > err > rty.
  - No response: counter increments each cycle. When counter == TIMEOUT-1 and no response arrives, go to RESP with err.
  - A response in that same cycle wins over the timeout.
  - wb_cyc_i low in any ACCESS cycle: abort. Go to IDLE, drop tgt_stb, no Wishbone response, no count.
- RESP: exactly one of wb_ack_o/wb_err_o/wb_rty_o high for one cycle, tgt_stb low. wb_stb_i is ignored in this cycle. Next state is always IDLE.
- wb_dat_o holds its value until the next RESP; it is 0 after reset.
- err_count increments by 1 on entry to RESP with err and saturates at all-ones. It never wraps.
- Reset (asynchronous, any state, including mid-ACCESS): state IDLE. All outputs 0: wb_*_o, tgt_stb, tgt_adr, tgt_we, tgt_dat_o, err_count. Timeout counter 0. A pending target access is dropped without response.

## Timing
- The request is sampled at edge E0. tgt_stb is high from E0 until the edge at which the response is sampled.
- Combinational target that responds in the first strobe cycle: wb_ack_o is high in the cycle after E1 (2-cycle strobe-to-ack).
- Target responding k cycles after strobe: Wishbone response appears k+2 cycles after E0.
- Timeout: err appears TIMEOUT+1 cycles after E0.
- Unmapped access: err in the cycle after E0.
- Back-to-back: a new request can be sampled at the edge ending RESP+1 (IDLE). Minimum 3 cycles per access.
- tgt_adr, tgt_we and tgt_dat_o are stable for the whole strobe.

## Test plan
- Read conf: wb_adr_i=0x0000_0004, target 0 acks combinationally with 0x0000_0010. Required: tgt_stb=3'b001 for one cycle, tgt_adr=0x0004, wb_ack_o pulse 2 cycles after request, wb_dat_o=0x10.
- Write DMA: wb_adr_i=0x0000_8010, wb_dat_i=0xDEADBEEF, target 2 acks after 3 cycles. Required: tgt_stb=3'b100 for 4 cycles, tgt_adr=0x0010, tgt_dat_o=0xDEADBEEF, tgt_we=1, ack 5 cycles after request.
- Unmapped: wb_adr_i=0x0000_C000. Required: no tgt_stb, wb_err_o the next cycle, err_count 0→1.
- Timeout with TIMEOUT=4 and a silent target 1. Required: tgt_stb=3'b010 for 4 cycles, then wb_err_o, err_count+1. Repeat with ack in the timeout cycle: ack wins and the count is unchanged.
- Priority and isolation: target 0 selected drives ack and err together, target 1 drives ack. Required: only ack from target 0, data from tgt_dat_i[31:0]. Separately, target 0 drives rty: wb_rty_o pulse, err_count unchanged.
- Abort and reset: wb_cyc_i dropped in the 2nd ACCESS cycle → tgt_stb low next cycle, no response. Then rst asserted mid-ACCESS without a clock edge → all outputs 0 immediately. Saturation with CNT_WIDTH=2: 5 errors → err_count=3.
